oneshot_gen: RTL and testbench
==============================

Name: oneshot_gen

Overview:
- Parameterised monostable (one-shot) pulse generator.
- A rising edge on the synchronous input din produces an output pulse exactly PULSE_LEN clock cycles long.
- Optional modes:
  - RETRIGGER: a new edge restarts a pulse already in progress.
  - HOLD: the output stays high while din is high, then stretches for PULSE_LEN cycles after din falls.
- Used for pulse stretching and for shaping short strobes for I/O and timing logic.

Parameters:
- PULSE_LEN, default 60: pulse length in clk cycles. Legal range 1..2^24-1.
- RETRIGGER, default 0: 1 means a rising edge during an active pulse reloads the counter. 0 means such an edge is ignored.
- HOLD, default 0: 1 means the counter reloads on every cycle din is high (level-sensitive). 0 means edge-triggered only.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- din  input  1  trigger input, synchronous to clk; no internal synchroniser.
- dout  output  1  one-shot pulse output.

Behaviour:
- State:
  - cnt: width $clog2(PULSE_LEN+1), minimum 1 bit.
  - din_d: previous sample of din.
- Reset (rst=1, asynchronous): cnt=0, din_d=1, dout=0.
  - din_d resets to 1, so a din already high at reset release does not trigger in edge mode.
  - When HOLD=1, that case does trigger, because HOLD is level-based.
- rise = din & ~din_d, evaluated at each clk edge; din_d <= din every cycle.
- dout = (cnt != 0). It is driven from the registered count, combinational from cnt only, and glitch-free.
- Per-edge counter update, priority top to bottom:
  - HOLD=1 and din=1: cnt <= PULSE_LEN.
  - rise and RETRIGGER=1: cnt <= PULSE_LEN.
  - rise and RETRIGGER=0 and cnt <= 1: cnt <= PULSE_LEN. The last pulse cycle accepts a new edge, giving a back-to-back pulse with no gap.
  - rise and RETRIGGER=0 and cnt > 1: edge ignored; cnt <= cnt-1.
  - otherwise, if cnt != 0: cnt <= cnt-1.
- Latency: dout rises immediately after the first clk edge that samples din=1 with din_d=0 (one-cycle latency).
  - Edge mode: dout is high for exactly PULSE_LEN cycles.
  - HOLD=1: dout is high for N+PULSE_LEN-1 cycles, where N is the number of edges sampling din=1 in the high run.
- Pulse width is independent of din width. A din pulse shorter than one clock but sampled high once still yields a full PULSE_LEN pulse. A din high time not sampled by any edge is lost.
- PULSE_LEN=1, HOLD=0: a single-cycle strobe per rising edge.
- PULSE_LEN=1, HOLD=1: dout is din delayed one cycle.
- Reset mid-pulse: dout falls asynchronously; no pulse resumes after release.
- No counter wrap: cnt never decrements below 0 and never loads above PULSE_LEN.

Test Plan:
- Clock period 2 units, PULSE_LEN=60, RETRIGGER=0, HOLD=0. Drive din high for 5 cycles -> dout high exactly 60 cycles from the first sampling edge, then low.
- Same config; din edges at cycle 0 and cycle 35 -> single 60-cycle pulse; the second edge is ignored.
- PULSE_LEN=60, RETRIGGER=1; edges at cycle 0 and cycle 35 -> dout high continuously for 95 cycles.
- PULSE_LEN=1, HOLD=1; din high 95 cycles -> dout high 95 cycles, delayed 1 cycle. PULSE_LEN=1, HOLD=0, same stimulus -> one 1-cycle strobe.
- PULSE_LEN=60, RETRIGGER=0: second edge exactly on the last pulse cycle (cnt=1) -> 120 contiguous high cycles.
- Assert rst at cycle 20 of a 60-cycle pulse -> dout 0 immediately. Release rst with din held high, HOLD=0 -> no pulse.

Source files
------------

// File: rtl/oneshot_gen_if.sv
// Trigger/pulse bundle for the one-shot generator.
// The master drives the trigger and observes the pulse. The slave (the generator) does the reverse.
`timescale 1ns/1ps

interface oneshot_gen_if;
    logic din;   // trigger, synchronous to the generator clock
    logic dout;  // one-shot pulse

    modport master (output din, input dout);
    modport slave  (input din, output dout);
endinterface

// File: rtl/oneshot_gen.sv
// Monostable pulse generator.
// A rising edge on din produces a pulse PULSE_LEN clocks long.
// RETRIGGER lets a new edge restart a running pulse.
// HOLD keeps the pulse high while din is high, then stretches it for PULSE_LEN clocks.
`timescale 1ns/1ps

module oneshot_gen #(
    parameter int unsigned PULSE_LEN = 60,   // 1 .. 2**24-1
    parameter bit          RETRIGGER = 1'b0,
    parameter bit          HOLD      = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    oneshot_gen_if.slave bus
);

    localparam int unsigned CW = (PULSE_LEN > 1) ? $clog2(PULSE_LEN + 1) : 1;
    localparam logic [CW-1:0] LOAD = CW'(PULSE_LEN);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic          din_d;
    logic          rise;

    // din_d resets high, so a din already high at reset release is not seen as an edge.
    assign rise = bus.din & ~din_d;

    // Next counter value: level hold, then (re)trigger, then count down toward zero.
    always_comb begin
        // NOTE: default first so every path assigns cnt_next and no latch is inferred.
        cnt_next = cnt;
        if (HOLD && bus.din) begin
            cnt_next = LOAD;
        end else if (rise && (RETRIGGER || cnt <= ONE)) begin
            // With cnt==1 this is the last pulse cycle, so the new pulse follows with no gap.
            cnt_next = LOAD;
        end else if (cnt != '0) begin
            cnt_next = cnt - ONE;
        end
    end

    // Counter and previous-din registers. Reset clears the pulse immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: non-blocking assignments in clocked logic so all registers update together.
            cnt   <= '0;
            din_d <= 1'b1;
        end else begin
            cnt   <= cnt_next;
            din_d <= bus.din;
        end
    end

    // The output is decoded from the registered count only, so it carries no glitches from din.
    assign bus.dout = (cnt != '0);

endmodule

// File: tb/tb_oneshot_gen.sv
// Directed bench for oneshot_gen.
// Five configurations share one din and are observed together:
//   0: PULSE_LEN=60, edge mode
//   1: PULSE_LEN=60, RETRIGGER
//   2: PULSE_LEN=1, HOLD
//   3: PULSE_LEN=1, edge mode
//   4: PULSE_LEN=4, HOLD
// Cycle c is the clk edge that samples the din value driven for c. Outputs are sampled on the
// falling edge after that clk edge, and the statistics are indexed by the cycle that produced them.
`timescale 1ns/1ps

module tb_oneshot_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       din;
    logic [4:0] douts;

    int n_vec = 0;
    int n_err = 0;

    int hi     [5];
    int pulses [5];
    int first  [5];
    int last   [5];
    logic prev [5];

    oneshot_gen_if if_a ();
    oneshot_gen_if if_b ();
    oneshot_gen_if if_c ();
    oneshot_gen_if if_d ();
    oneshot_gen_if if_e ();

    assign if_a.din = din;
    assign if_b.din = din;
    assign if_c.din = din;
    assign if_d.din = din;
    assign if_e.din = din;
    assign douts = {if_e.dout, if_d.dout, if_c.dout, if_b.dout, if_a.dout};

    oneshot_gen #(.PULSE_LEN(60), .RETRIGGER(1'b0), .HOLD(1'b0)) dut_a (.clk(clk), .rst(rst), .bus(if_a));
    oneshot_gen #(.PULSE_LEN(60), .RETRIGGER(1'b1), .HOLD(1'b0)) dut_b (.clk(clk), .rst(rst), .bus(if_b));
    oneshot_gen #(.PULSE_LEN(1),  .RETRIGGER(1'b0), .HOLD(1'b1)) dut_c (.clk(clk), .rst(rst), .bus(if_c));
    oneshot_gen #(.PULSE_LEN(1),  .RETRIGGER(1'b0), .HOLD(1'b0)) dut_d (.clk(clk), .rst(rst), .bus(if_d));
    oneshot_gen #(.PULSE_LEN(4),  .RETRIGGER(1'b0), .HOLD(1'b1)) dut_e (.clk(clk), .rst(rst), .bus(if_e));

    // Clock with a period of 2.
    always #1 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        din = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic sample(input int idx);
        for (int k = 0; k < 5; k++) begin
            if (douts[k]) begin
                hi[k]++;
                if (first[k] < 0) first[k] = idx;
                last[k] = idx;
                if (!prev[k]) pulses[k]++;
            end
            prev[k] = douts[k];
        end
    endtask

    // din is high during cycles [s1, s1+l1) and [s2, s2+l2). Sampling runs for `total` cycles.
    task automatic run(input int s1, input int l1, input int s2, input int l2, input int total);
        for (int k = 0; k < 5; k++) begin
            hi[k] = 0; pulses[k] = 0; first[k] = -1; last[k] = -1; prev[k] = 1'b0;
        end
        for (int c = 0; c < total; c++) begin
            @(negedge clk);
            if (c > 0) sample(c - 1);
            din = ((c >= s1) && (c < s1 + l1)) || ((c >= s2) && (c < s2 + l2));
        end
        @(negedge clk);
        sample(total - 1);
        din = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cnt_a;
        int cnt_e;
        rst = 1'b1;
        din = 1'b0;
        #3;
        check("reset_dout_all", int'(douts), 0);

        // din high for 5 cycles
        do_reset();
        run(0, 5, 0, 0, 140);
        check("c1_a_high",   hi[0], 60);
        check("c1_a_first",  first[0], 0);
        check("c1_a_last",   last[0], 59);
        check("c1_a_pulses", pulses[0], 1);
        check("c1_b_high",   hi[1], 60);
        check("c1_c_high",   hi[2], 5);
        check("c1_c_first",  first[2], 0);
        check("c1_d_high",   hi[3], 1);
        check("c1_e_high",   hi[4], 8);
        check("c1_e_last",   last[4], 7);

        // Edges at cycles 0 and 35
        do_reset();
        run(0, 1, 35, 1, 140);
        check("c2_a_high",   hi[0], 60);
        check("c2_a_pulses", pulses[0], 1);
        check("c2_b_high",   hi[1], 95);
        check("c2_b_pulses", pulses[1], 1);
        check("c2_b_last",   last[1], 94);
        check("c2_c_pulses", pulses[2], 2);
        check("c2_d_pulses", pulses[3], 2);
        check("c2_e_high",   hi[4], 8);
        check("c2_e_pulses", pulses[4], 2);

        // din high for 95 cycles
        do_reset();
        run(0, 95, 0, 0, 140);
        check("c3_c_high",   hi[2], 95);
        check("c3_c_first",  first[2], 0);
        check("c3_c_pulses", pulses[2], 1);
        check("c3_d_high",   hi[3], 1);
        check("c3_a_high",   hi[0], 60);
        check("c3_b_high",   hi[1], 60);
        check("c3_e_high",   hi[4], 98);

        // Second edge sampled when cnt==1 (cycle 60): back-to-back pulses
        do_reset();
        run(0, 1, 60, 1, 160);
        check("c4_a_high",   hi[0], 120);
        check("c4_a_pulses", pulses[0], 1);
        check("c4_a_last",   last[0], 119);
        check("c4_d_pulses", pulses[3], 2);

        // Second edge sampled when cnt==2 (cycle 59): ignored without RETRIGGER
        do_reset();
        run(0, 1, 59, 1, 160);
        check("c5_a_high",   hi[0], 60);
        check("c5_a_pulses", pulses[0], 1);
        check("c5_b_high",   hi[1], 119);

        // Reset asserted mid-pulse, then released with din held high
        do_reset();
        run(0, 1, 0, 0, 21);
        check("c6_a_mid_pulse", int'(douts[0]), 1);
        #0.5;
        rst = 1'b1;
        din = 1'b1;
        #0.2;
        check("c6_a_async_clear", int'(douts[0]), 0);
        check("c6_b_async_clear", int'(douts[1]), 0);
        @(negedge clk);
        rst = 1'b0;
        cnt_a = 0;
        cnt_e = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (douts[0]) cnt_a++;
            if (douts[4]) cnt_e++;
        end
        din = 1'b0;
        check("c6_a_no_pulse_after_release", cnt_a, 0);
        check("c6_e_hold_after_release",     cnt_e, 80);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
